// File: rtl/lfsr_core_if.sv
// Register-block side of the LFSR stage: control, seed and taps in, state and status out.
// The master is the AXI-Lite register block; the slave is lfsr_core.
interface lfsr_core_if;
  logic [7:0]  ctrl_reg;
  logic [7:0]  seed_reg;
  logic [7:0]  taps_reg;
  logic [7:0]  lfsr_data;
  logic        lfsr_valid;
  logic        lockup;
  logic [15:0] adv_count;

  modport master (
    output ctrl_reg, seed_reg, taps_reg,
    input  lfsr_data, lfsr_valid, lockup, adv_count
  );

  modport slave (
    input  ctrl_reg, seed_reg, taps_reg,
    output lfsr_data, lfsr_valid, lockup, adv_count
  );
endinterface

// File: rtl/lfsr_core.sv
// 8-bit Fibonacci/Galois LFSR with rate divider, single-step, advance counter
// and sticky zero-state lockup. All outputs come straight from registers.
module lfsr_core (
  input  logic        clk,
  input  logic        reset,
  lfsr_core_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, LOCKED} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  ctrl_q_reg;          // previous load/step bits for edge detection
  logic [7:0]  data_reg, data_next;
  logic        valid_reg, valid_next;
  logic        lockup_reg, lockup_next;
  logic [15:0] count_reg, count_next;
  logic [3:0]  div_cnt_reg, div_cnt_next;

  logic       enable, mode;
  logic [3:0] div;
  logic       load_evt, step_evt, advance;
  logic [7:0] fib_next, gal_next, adv_value;

  assign enable   = bus.ctrl_reg[0];
  assign mode     = bus.ctrl_reg[3];
  assign div      = bus.ctrl_reg[7:4];
  assign load_evt = bus.ctrl_reg[1] & ~ctrl_q_reg[0];
  assign step_evt = bus.ctrl_reg[2] & ~ctrl_q_reg[1];

  assign fib_next  = {data_reg[6:0], ^(data_reg & bus.taps_reg)};
  assign gal_next  = {data_reg[6:0], 1'b0} ^ (data_reg[7] ? bus.taps_reg : 8'h00);
  assign adv_value = mode ? gal_next : fib_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    data_next    = data_reg;
    valid_next   = 1'b0;
    lockup_next  = lockup_reg;
    count_next   = count_reg;
    div_cnt_next = div_cnt_reg;
    advance      = 1'b0;

    if (load_evt) begin
      // Load overrides any due advance or step in the same cycle.
      data_next    = (bus.seed_reg == 8'h00) ? 8'h01 : bus.seed_reg;
      count_next   = 16'h0000;
      lockup_next  = 1'b0;
      div_cnt_next = 4'd0;
      valid_next   = 1'b1;
      state_next   = enable ? RUN : IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (enable) begin
            state_next   = RUN;
            div_cnt_next = 4'd0;
          end else if (step_evt) begin
            advance = 1'b1;
          end
        end
        RUN: begin
          if (!enable) begin
            state_next   = IDLE;
            div_cnt_next = 4'd0;
          end else if (div_cnt_reg == div) begin
            advance      = 1'b1;
            div_cnt_next = 4'd0;
          end else begin
            div_cnt_next = div_cnt_reg + 4'd1;
          end
        end
        LOCKED: begin
          state_next = LOCKED;
        end
        default: begin
          state_next = IDLE;
        end
      endcase

      if (advance) begin
        data_next  = adv_value;
        count_next = count_reg + 16'd1;
        valid_next = 1'b1;
        if (adv_value == 8'h00) begin
          lockup_next = 1'b1;
          state_next  = LOCKED;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q_reg  <= 2'b00;
      data_reg    <= 8'h01;
      valid_reg   <= 1'b0;
      lockup_reg  <= 1'b0;
      count_reg   <= 16'h0000;
      div_cnt_reg <= 4'd0;
    end else begin
      ctrl_q_reg  <= bus.ctrl_reg[2:1];
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      lockup_reg  <= lockup_next;
      count_reg   <= count_next;
      div_cnt_reg <= div_cnt_next;
    end
  end

  assign bus.lfsr_data  = data_reg;
  assign bus.lfsr_valid = valid_reg;
  assign bus.lockup     = lockup_reg;
  assign bus.adv_count  = count_reg;

endmodule

// File: tb/tb_lfsr_core.sv
// Directed bench for lfsr_core: a per-cycle vector table plus hand-written
// divider, lockup, async-reset and counter-wrap sequences.
module tb_lfsr_core;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  lfsr_core_if bus ();

  lfsr_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ctrl;
    logic [7:0]  seed;
    logic [7:0]  taps;
    logic [7:0]  data;
    logic        valid;
    logic        lock;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] d, input logic v,
                           input logic l, input logic [15:0] c);
    check({tag, ".data"},   {8'h00, bus.lfsr_data}, {8'h00, d});
    check({tag, ".valid"},  {15'h0, bus.lfsr_valid}, {15'h0, v});
    check({tag, ".lockup"}, {15'h0, bus.lockup}, {15'h0, l});
    check({tag, ".count"},  bus.adv_count, c);
  endtask

  task automatic drive(input logic [7:0] c, input logic [7:0] s, input logic [7:0] t);
    bus.ctrl_reg = c;
    bus.seed_reg = s;
    bus.taps_reg = t;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    drive(8'h00, 8'h00, 8'h00);

    // ctrl, seed, taps -> data, valid, lockup, count after the edge
    vecs.push_back('{8'h02, 8'h01, 8'hB8, 8'h01, 1'b1, 1'b0, 16'd0}); // load
    vecs.push_back('{8'h00, 8'h01, 8'hB8, 8'h01, 1'b0, 1'b0, 16'd0});
    vecs.push_back('{8'h04, 8'h01, 8'hB8, 8'h02, 1'b1, 1'b0, 16'd1}); // fib steps
    vecs.push_back('{8'h00, 8'h01, 8'hB8, 8'h02, 1'b0, 1'b0, 16'd1});
    vecs.push_back('{8'h04, 8'h01, 8'hB8, 8'h04, 1'b1, 1'b0, 16'd2});
    vecs.push_back('{8'h00, 8'h01, 8'hB8, 8'h04, 1'b0, 1'b0, 16'd2});
    vecs.push_back('{8'h04, 8'h01, 8'hB8, 8'h08, 1'b1, 1'b0, 16'd3});
    vecs.push_back('{8'h00, 8'h01, 8'hB8, 8'h08, 1'b0, 1'b0, 16'd3});
    vecs.push_back('{8'h04, 8'h01, 8'hB8, 8'h11, 1'b1, 1'b0, 16'd4});
    vecs.push_back('{8'h00, 8'h01, 8'hB8, 8'h11, 1'b0, 1'b0, 16'd4});
    vecs.push_back('{8'h02, 8'h80, 8'hB8, 8'h80, 1'b1, 1'b0, 16'd0}); // galois load
    vecs.push_back('{8'h00, 8'h80, 8'hB8, 8'h80, 1'b0, 1'b0, 16'd0});
    vecs.push_back('{8'h09, 8'h80, 8'hB8, 8'h80, 1'b0, 1'b0, 16'd0}); // RUN entry
    vecs.push_back('{8'h09, 8'h80, 8'hB8, 8'hB8, 1'b1, 1'b0, 16'd1});
    vecs.push_back('{8'h09, 8'h80, 8'hB8, 8'hC8, 1'b1, 1'b0, 16'd2});
    vecs.push_back('{8'h00, 8'h80, 8'hB8, 8'hC8, 1'b0, 1'b0, 16'd2}); // disable
    vecs.push_back('{8'h0C, 8'h80, 8'hB8, 8'h28, 1'b1, 1'b0, 16'd3}); // galois step
    vecs.push_back('{8'h08, 8'h80, 8'hB8, 8'h28, 1'b0, 1'b0, 16'd3});
    vecs.push_back('{8'h02, 8'h00, 8'hB8, 8'h01, 1'b1, 1'b0, 16'd0}); // zero seed
    vecs.push_back('{8'h00, 8'h00, 8'hB8, 8'h01, 1'b0, 1'b0, 16'd0});
    vecs.push_back('{8'h05, 8'h00, 8'hB8, 8'h01, 1'b0, 1'b0, 16'd0}); // step+enable edge
    vecs.push_back('{8'h00, 8'h00, 8'hB8, 8'h01, 1'b0, 1'b0, 16'd0});
    vecs.push_back('{8'h01, 8'h00, 8'hB8, 8'h01, 1'b0, 1'b0, 16'd0}); // RUN entry
    vecs.push_back('{8'h03, 8'h5A, 8'hB8, 8'h5A, 1'b1, 1'b0, 16'd0}); // load vs advance
    vecs.push_back('{8'h01, 8'h5A, 8'hB8, 8'hB4, 1'b1, 1'b0, 16'd1});
    vecs.push_back('{8'h00, 8'h5A, 8'hB8, 8'hB4, 1'b0, 1'b0, 16'd1});

    tick();
    tick();
    check_all("reset_held", 8'h01, 1'b0, 1'b0, 16'd0);
    reset = 1'b0;
    tick();
    check_all("reset_release", 8'h01, 1'b0, 1'b0, 16'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].ctrl, vecs[i].seed, vecs[i].taps);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].data, vecs[i].valid, vecs[i].lock, vecs[i].cnt);
      $display("vec %0d ctrl=0x%02h data=0x%02h valid=%0b count=%0d",
               i, vecs[i].ctrl, bus.lfsr_data, bus.lfsr_valid, bus.adv_count);
    end

    // Divider: div=3 gives a pulse every 4 cycles; re-enable restarts spacing.
    drive(8'h02, 8'h01, 8'hB8); tick();
    drive(8'h00, 8'h01, 8'hB8); tick();
    drive(8'h31, 8'h01, 8'hB8); tick();
    for (int i = 1; i <= 18; i++) begin
      tick();
      check($sformatf("div_valid%0d", i), {15'h0, bus.lfsr_valid}, {15'h0, (i % 4 == 0)});
    end
    drive(8'h30, 8'h01, 8'hB8);
    for (int i = 1; i <= 2; i++) begin
      tick();
      check($sformatf("div_off%0d", i), {15'h0, bus.lfsr_valid}, 16'h0);
    end
    drive(8'h31, 8'h01, 8'hB8); tick();
    check("div_reentry", {15'h0, bus.lfsr_valid}, 16'h0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("div_re_valid%0d", i), {15'h0, bus.lfsr_valid}, {15'h0, (i % 4 == 0)});
    end
    $display("divider sequence done count=%0d", bus.adv_count);

    // Lockup: zero taps shift the single one out after 8 advances.
    drive(8'h02, 8'h01, 8'h00); tick();
    drive(8'h00, 8'h01, 8'h00); tick();
    drive(8'h01, 8'h01, 8'h00); tick();
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("lock_adv%0d", i), {15'h0, bus.lfsr_valid}, 16'h1);
    end
    check_all("lock_hit", 8'h00, 1'b1, 1'b1, 16'd8);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_all($sformatf("lock_hold%0d", i), 8'h00, 1'b0, 1'b1, 16'd8);
    end
    drive(8'h00, 8'h01, 8'h00); tick();
    drive(8'h04, 8'h01, 8'h00); tick();
    check_all("lock_step", 8'h00, 1'b0, 1'b1, 16'd8);
    drive(8'h02, 8'h5A, 8'h00); tick();
    check_all("lock_clear", 8'h5A, 1'b1, 1'b0, 16'd0);
    $display("lockup sequence done data=0x%02h lockup=%0b", bus.lfsr_data, bus.lockup);

    // Asynchronous reset between clock edges while running.
    drive(8'h01, 8'h5A, 8'hB8); tick();
    tick();
    tick();
    check("async_pre_count", bus.adv_count, 16'd2);
    #3;
    reset = 1'b1;
    #1;
    check_all("async_reset", 8'h01, 1'b0, 1'b0, 16'd0);
    drive(8'h00, 8'h5A, 8'hB8);
    tick();
    reset = 1'b0;
    tick();
    check_all("async_release", 8'h01, 1'b0, 1'b0, 16'd0);
    $display("async reset sequence done");

    // Counter wrap after 65536 advances at div 0.
    drive(8'h01, 8'h01, 8'hB8); tick();
    for (int i = 0; i < 65535; i++) tick();
    check("wrap_ffff", bus.adv_count, 16'hFFFF);
    tick();
    check("wrap_zero", bus.adv_count, 16'h0000);
    check("wrap_valid", {15'h0, bus.lfsr_valid}, 16'h1);
    $display("wrap sequence done count=0x%04h", bus.adv_count);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_core.md
# lfsr_core

Pseudo-random generator stage driven by the AXI-Lite register block. It consumes the control, seed and taps registers and produces the current 8-bit LFSR value, which the register block reads back at offset 0xC. The generator supports Fibonacci and Galois forms, a programmable advance-rate divider, single-step operation, an advance counter and zero-state lockup detection.

## Interface
- No parameters. Width is fixed at 8 bits to match the register file.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ctrl_reg  in  8  control word:
  - [0] enable
  - [1] load: rising edge loads the seed
  - [2] step: rising edge gives one advance, honoured only while disabled
  - [3] mode: 0 = Fibonacci, 1 = Galois
  - [7:4] div: advance every div+1 cycles
- seed_reg  in  8  seed value.
- taps_reg  in  8  feedback tap mask.
- lfsr_data  out  8  current LFSR state.
- lfsr_valid  out  1  one-cycle pulse, asserted in the cycle after each advance or load.
- lockup  out  1  sticky flag; set when the state becomes 0x00.
- adv_count  out  16  number of advances since the last load; wraps.

## Operation
- Reset: all of the following take these values until reset deasserts.
  - lfsr_data = 0x01
  - lfsr_valid = 0
  - lockup = 0
  - adv_count = 0x0000
  - div counter = 0
  - ctrl_q = 0x00
  - FSM = IDLE
- Edge detect: ctrl_q registers ctrl_reg every cycle.
  - load_evt = ctrl[1] & ~ctrl_q[1].
  - step_evt = ctrl[2] & ~ctrl_q[2].
- Next-state function, where s is the current state and t is taps_reg:
  - Fibonacci: next = {s[6:0], ^(s & t)}.
  - Galois: next = {s[6:0], 1'b0} ^ (s[7] ? t : 8'h00).
- FSM states:
  - IDLE
    - enable = 1 → RUN.
    - step_evt → advance once and stay in IDLE.
  - RUN
    - div counter counts 0..div.
    - When counter == div: advance and reset the counter to 0.
    - enable = 0 → IDLE, with the counter cleared.
    - step_evt is ignored.
  - LOCKED
    - No advances occur.
    - enable and step have no effect.
    - The only exits are load_evt or reset.
- Advance: lfsr_data <= next, adv_count <= adv_count + 1 (mod 2^16), lfsr_valid pulses the next cycle.
  - If next == 0x00, set lockup and go to LOCKED.
- Load: load_evt has priority over everything in any state.
  - lfsr_data <= (seed_reg == 0) ? 0x01 : seed_reg.
  - adv_count, lockup and the div counter are cleared.
  - lfsr_valid pulses the next cycle.
  - Next FSM state is RUN if enable = 1, otherwise IDLE.
- Simultaneous events:
  - Load with a due advance or a step: the load wins and no advance occurs.
  - Step in the same cycle as the enable rising edge: the step is ignored.
- mode and taps are sampled at each advance. Changing them mid-run takes effect on the next advance; there is no restart.

## Timing
- Latency for load_evt, step_evt or a due advance: lfsr_data and adv_count update at that clock edge, and lfsr_valid is high for exactly the following cycle.
- With enable held at 1 and div = d, advances occur every d+1 cycles.
  - The first advance happens d+1 cycles after the RUN entry edge.
  - With div = 0, an advance occurs every cycle and lfsr_valid stays high continuously.
- Reset assertion mid-run immediately forces all reset values, with no clock needed.
- The register block reads lfsr_data directly. Read data is the value registered at the read address cycle.
- No combinational path exists from any input to any output.

## Test plan
- Fibonacci walk: ctrl = 0x02 with seed 0x01 and taps 0xB8, then ctrl = 0x00, then four step pulses → lfsr_data 0x02, 0x04, 0x08, 0x11; adv_count = 4; four lfsr_valid pulses.
- Galois walk: seed 0x80, taps 0xB8, load, then ctrl = 0x09 (enable, Galois, div 0) → lfsr_data 0xB8, then 0xC8 on consecutive cycles.
- Divider: ctrl = 0x31 with seed 0x01 and taps 0xB8 → lfsr_valid pulses exactly every 4 cycles. Dropping enable mid-count then re-enabling restarts the 4-cycle spacing.
- Lockup: Fibonacci, taps 0x00, seed 0x01, run at div 0.
  - After 8 advances lfsr_data = 0x00 and lockup = 1.
  - Further cycles give no valid pulses and adv_count stays at 8.
  - A subsequent load with seed 0x5A clears lockup.
- Zero seed and collision: load with seed 0x00 → lfsr_data = 0x01. Load coincident with a due advance → lfsr_data = seed and adv_count = 0.
- Async reset and wrap:
  - Asserting reset between clock edges mid-run → outputs reach their reset values before the next edge.
  - Running to 65536 advances → adv_count wraps to 0x0000.
